// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, control-bundle bit positions
// and operand forward-select encoding.
package mips_pkg;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_SLT = 6'b101010;

  // Control bundle layout: {RegWrite, MemRead, MemWrite, MemToReg}
  localparam int unsigned CTRL_REG_WRITE  = 3;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  // r0 is hard-wired zero, so it is never bypassed; EX/MEM is the younger result.
  function automatic fwdSel_t fwdSelect(input logic       exMemRegWrite,
                                        input logic [4:0] exMemRd,
                                        input logic       memWbRegWrite,
                                        input logic [4:0] memWbRd,
                                        input logic [4:0] addr);
    if (addr == '0)                           return FWD_REG;
    if (exMemRegWrite && (exMemRd == addr))   return FWD_MEM;
    if (memWbRegWrite && (memWbRd == addr))   return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX data bundle: decode-side operands, bypass buses and EX-side outputs.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
);
  logic [DATA_W-1:0] InRsData;
  logic [DATA_W-1:0] InRtData;
  logic [DATA_W-1:0] InImm;
  logic [4:0]        InRs;
  logic [4:0]        InRt;
  logic [4:0]        InRd;
  logic [OP_W-1:0]   InOperation;
  logic              InAluSrc;
  logic [3:0]        InCtrl;

  logic              ExMemRegWrite;
  logic [4:0]        ExMemRd;
  logic [DATA_W-1:0] ExMemResult;
  logic              MemWbRegWrite;
  logic [4:0]        MemWbRd;
  logic [DATA_W-1:0] MemWbResult;

  logic [DATA_W-1:0] DataA;
  logic [DATA_W-1:0] DataB;
  logic [OP_W-1:0]   Operation;
  logic [DATA_W-1:0] StoreData;
  logic [4:0]        OutRd;
  logic [3:0]        OutCtrl;
  logic              OutValid;
  logic              LoadUseHazard;

  modport master (
    output InRsData, InRtData, InImm, InRs, InRt, InRd, InOperation, InAluSrc, InCtrl,
    output ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbResult,
    input  DataA, DataB, Operation, StoreData, OutRd, OutCtrl, OutValid, LoadUseHazard
  );

  modport slave (
    input  InRsData, InRtData, InImm, InRs, InRt, InRd, InOperation, InAluSrc, InCtrl,
    input  ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbResult,
    output DataA, DataB, Operation, StoreData, OutRd, OutCtrl, OutValid, LoadUseHazard
  );
endinterface

// File: rtl/id_ex_stage_fwd.sv
// Forwarding unit: picks the operand source for the registered rs and rt.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] rsAddr,
  input  logic [4:0] rtAddr,
  input  logic       exMemRegWrite,
  input  logic [4:0] exMemRd,
  input  logic       memWbRegWrite,
  input  logic [4:0] memWbRd,
  output fwdSel_t    fwdA,
  output fwdSel_t    fwdB
);

  assign fwdA = fwdSelect(exMemRegWrite, exMemRd, memWbRegWrite, memWbRd, rsAddr);
  assign fwdB = fwdSelect(exMemRegWrite, exMemRd, memWbRegWrite, memWbRd, rtAddr);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and load-use detection.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
)(
  input logic          Clk,
  input logic          Reset,
  input logic          Stall,
  input logic          Flush,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [OP_W-1:0]   op;
    logic              aluSrc;
    logic [3:0]        ctrl;
    logic              valid;
  } stage_t;

  stage_t            q;
  stage_t            loadVal;
  fwdSel_t           fwdA;
  fwdSel_t           fwdB;
  logic [DATA_W-1:0] fwdRs;
  logic [DATA_W-1:0] fwdRt;

  always_comb begin
    loadVal        = '0;
    loadVal.rsData = bus.InRsData;
    loadVal.rtData = bus.InRtData;
    loadVal.imm    = bus.InImm;
    loadVal.rs     = bus.InRs;
    loadVal.rt     = bus.InRt;
    loadVal.rd     = bus.InRd;
    loadVal.op     = bus.InOperation;
    loadVal.aluSrc = bus.InAluSrc;
    loadVal.ctrl   = bus.InCtrl;
    loadVal.valid  = 1'b1;
  end

  // Flush outranks Stall, so a stalled stage can still be turned into a bubble.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= '0;
    end else if (Flush) begin
      q <= '0;
    end else if (!Stall) begin
      q <= loadVal;
    end
  end

  fwd_unit uFwd (
    .rsAddr        (q.rs),
    .rtAddr        (q.rt),
    .exMemRegWrite (bus.ExMemRegWrite),
    .exMemRd       (bus.ExMemRd),
    .memWbRegWrite (bus.MemWbRegWrite),
    .memWbRd       (bus.MemWbRd),
    .fwdA          (fwdA),
    .fwdB          (fwdB)
  );

  always_comb begin
    fwdRs = q.rsData;
    case (fwdA)
      FWD_MEM: fwdRs = bus.ExMemResult;
      FWD_WB:  fwdRs = bus.MemWbResult;
      default: fwdRs = q.rsData;
    endcase
  end

  always_comb begin
    fwdRt = q.rtData;
    case (fwdB)
      FWD_MEM: fwdRt = bus.ExMemResult;
      FWD_WB:  fwdRt = bus.MemWbResult;
      default: fwdRt = q.rtData;
    endcase
  end

  assign bus.DataA     = fwdRs;
  assign bus.DataB     = q.aluSrc ? q.imm : fwdRt;
  assign bus.StoreData = fwdRt;
  assign bus.Operation = q.op;
  assign bus.OutRd     = q.rd;
  assign bus.OutCtrl   = q.ctrl;
  assign bus.OutValid  = q.valid;

  assign bus.LoadUseHazard = q.valid && q.ctrl[CTRL_MEM_READ] && (q.rd != '0) &&
                             ((q.rd == bus.InRs) || (q.rd == bus.InRt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; a driver queues expected outputs and a
// negedge monitor pops and compares them.
module tb_id_ex_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic        rst, stall, flush;
    logic [31:0] rsData, rtData, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op;
    logic        aluSrc;
    logic [3:0]  ctrl;
    logic        exW;
    logic [4:0]  exRd;
    logic [31:0] exRes;
    logic        wbW;
    logic [4:0]  wbRd;
    logic [31:0] wbRes;
  } stim_t;

  typedef struct packed {
    logic [31:0] dataA, dataB, store;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        valid, hz;
  } exp_t;

  logic Clk;
  logic Reset;
  logic Stall;
  logic Flush;

  id_ex_stage_if #(.DATA_W(32), .OP_W(6)) bus ();

  id_ex_stage #(.DATA_W(32), .OP_W(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Stall (Stall),
    .Flush (Flush),
    .bus   (bus.slave)
  );

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] st, input logic [5:0] op,
                              input logic [4:0] rd, input logic [3:0] ctrl,
                              input logic v, input logic hz);
    exp_t e;
    e.dataA = a; e.dataB = b; e.store = st; e.op = op;
    e.rd = rd; e.ctrl = ctrl; e.valid = v; e.hz = hz;
    return e;
  endfunction

  task automatic drive(input stim_t st);
    Reset             = st.rst;
    Stall             = st.stall;
    Flush             = st.flush;
    bus.InRsData      = st.rsData;
    bus.InRtData      = st.rtData;
    bus.InImm         = st.imm;
    bus.InRs          = st.rs;
    bus.InRt          = st.rt;
    bus.InRd          = st.rd;
    bus.InOperation   = st.op;
    bus.InAluSrc      = st.aluSrc;
    bus.InCtrl        = st.ctrl;
    bus.ExMemRegWrite = st.exW;
    bus.ExMemRd       = st.exRd;
    bus.ExMemResult   = st.exRes;
    bus.MemWbRegWrite = st.wbW;
    bus.MemWbRd       = st.wbRd;
    bus.MemWbResult   = st.wbRes;
  endtask

  // Inputs land just after a rising edge; the expectation covers the following
  // falling edge (state from that edge plus the bypass/In values just applied).
  task automatic apply(input stim_t st, input exp_t ex);
    @(posedge Clk);
    #1;
    drive(st);
    expQ.push_back(ex);
  endtask

  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      exp_t a;
      e = expQ.pop_front();
      a.dataA = bus.DataA;     a.dataB = bus.DataB;   a.store = bus.StoreData;
      a.op    = bus.Operation; a.rd    = bus.OutRd;   a.ctrl  = bus.OutCtrl;
      a.valid = bus.OutValid;  a.hz    = bus.LoadUseHazard;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got A=%h B=%h St=%h op=%h rd=%0d ctrl=%b v=%b hz=%b; expected A=%h B=%h St=%h op=%h rd=%0d ctrl=%b v=%b hz=%b",
                 vectors, a.dataA, a.dataB, a.store, a.op, a.rd, a.ctrl, a.valid, a.hz,
                 e.dataA, e.dataB, e.store, e.op, e.rd, e.ctrl, e.valid, e.hz);
      end
      vectors++;
    end
  end

  initial begin
    stim_t s;
    exp_t  bub;
    bub = '0;
    s   = '0;
    s.rst = 1'b1;
    drive(s);

    apply(s, bub);                                                   // reset state
    s.rst = 1'b0;
    s.rsData = 32'd2; s.rtData = 32'd3; s.op = ALU_ADD;
    s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd3; s.ctrl = 4'b1000;
    apply(s, bub);
    s.rsData = 32'h11; s.rtData = 32'h22; s.rs = 5'd5; s.rt = 5'd6; s.rd = 5'd9; s.op = ALU_SUB;
    apply(s, mk(32'd2, 32'd3, 32'd3, ALU_ADD, 5'd3, 4'b1000, 1'b1, 1'b0));
    s.exW = 1'b1; s.exRd = 5'd5; s.exRes = 32'h10;                   // both stages match rs
    s.wbW = 1'b1; s.wbRd = 5'd5; s.wbRes = 32'h20;
    apply(s, mk(32'h10, 32'h22, 32'h22, ALU_SUB, 5'd9, 4'b1000, 1'b1, 1'b0));
    s.exW = 1'b0; s.rsData = 32'h33; s.rs = 5'd0;
    apply(s, mk(32'h20, 32'h22, 32'h22, ALU_SUB, 5'd9, 4'b1000, 1'b1, 1'b0));
    s.exW = 1'b1; s.exRd = 5'd0; s.wbRd = 5'd0;                      // r0 never bypassed
    s.rsData = 32'h40; s.rtData = 32'h50; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd7;
    s.op = ALU_ADD; s.aluSrc = 1'b1; s.imm = 32'd4; s.ctrl = 4'b1101;
    apply(s, mk(32'h33, 32'h22, 32'h22, ALU_SUB, 5'd9, 4'b1000, 1'b1, 1'b0));
    s.stall = 1'b1; s.rs = 5'd7; s.rt = 5'd9;                        // lw in stage, rs hits
    s.exW = 1'b1; s.exRd = 5'd2; s.exRes = 32'h99; s.wbW = 1'b0;
    apply(s, mk(32'h40, 32'd4, 32'h99, ALU_ADD, 5'd7, 4'b1101, 1'b1, 1'b1));
    s.stall = 1'b0; s.rs = 5'd8; s.rt = 5'd9;
    s.rsData = 32'hA1; s.rtData = 32'hB2; s.rd = 5'd10; s.op = ALU_OR;
    s.ctrl = 4'b1000; s.aluSrc = 1'b0; s.imm = 32'd0;
    s.exW = 1'b0; s.wbW = 1'b1; s.wbRd = 5'd2; s.wbRes = 32'h66;
    apply(s, mk(32'h40, 32'd4, 32'h66, ALU_ADD, 5'd7, 4'b1101, 1'b1, 1'b0));
    s.stall = 1'b1; s.wbW = 1'b0;
    s.rsData = 32'd1; s.rtData = 32'd2; s.rs = 5'd11; s.rt = 5'd12; s.rd = 5'd13;
    s.op = ALU_AND; s.ctrl = 4'b0100; s.aluSrc = 1'b1; s.imm = 32'h55;
    apply(s, mk(32'hA1, 32'hB2, 32'hB2, ALU_OR, 5'd10, 4'b1000, 1'b1, 1'b0));
    s.rsData = 32'd3; s.op = ALU_SLT; s.rs = 5'd10;
    apply(s, mk(32'hA1, 32'hB2, 32'hB2, ALU_OR, 5'd10, 4'b1000, 1'b1, 1'b0));
    s.rsData = 32'd5; s.rtData = 32'd6;
    apply(s, mk(32'hA1, 32'hB2, 32'hB2, ALU_OR, 5'd10, 4'b1000, 1'b1, 1'b0));
    s.flush = 1'b1;                                                  // flush while stalled
    apply(s, mk(32'hA1, 32'hB2, 32'hB2, ALU_OR, 5'd10, 4'b1000, 1'b1, 1'b0));
    s.stall = 1'b0; s.flush = 1'b0;
    s.rsData = 32'h77; s.rtData = 32'h88; s.imm = 32'hFFFF_FFFC; s.aluSrc = 1'b1;
    s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd4; s.op = ALU_ADD; s.ctrl = 4'b1000;
    apply(s, bub);
    apply(s, mk(32'h77, 32'hFFFF_FFFC, 32'h88, ALU_ADD, 5'd4, 4'b1000, 1'b1, 1'b0));
    s.rst = 1'b1;                                                    // async reset mid-cycle
    apply(s, bub);
    s.rst = 1'b0;
    apply(s, bub);
    s.flush = 1'b1;
    apply(s, mk(32'h77, 32'hFFFF_FFFC, 32'h88, ALU_ADD, 5'd4, 4'b1000, 1'b1, 1'b0));
    s.flush = 1'b0;
    apply(s, bub);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge Clk);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
